disp_source_sched: RTL and testbench
====================================

Name: disp_source_sched

Overview:
- Scheduler for the shared 3-digit multiplexed 7-segment display in the whack-a-mole game.
- Chooses which value drives the display's 12-bit BCD input: the countdown timer (default), the score (held after each hit), or a flashing score after game over.
- Cleans the BCD value before it reaches the display and gives a blank control that the top level uses to force all digit selects inactive.

Parameters:
- TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clock).
- HOLD_MS, 1000, ms the score stays shown after the last hit_pulse.
- FLASH_MS, 500, ms per flash half-period (on or off) in game-over state.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  synchronous active-low reset.
- time_bcd  in  12  countdown value, 3 BCD digits, [3:0] is units.
- score_bcd  in  12  score value, 3 BCD digits.
- hit_pulse  in  1  one-cycle pulse; a mole was hit.
- game_over  in  1  level signal; high while the game is ended.
- bcd  out  12  cleaned BCD value to the display driver.
- blank  out  1  1 = all digits dark.
- src  out  2  current source: 0 TIMER, 1 SCORE, 2 OVER_ON, 3 OVER_OFF.
- bcd_err  out  1  sticky flag; a source nibble was greater than 9.

Behaviour:
- One clock domain. Reset is synchronous and active-low: it is sampled only on the rising edge of clk while reset==0. Reset has priority over every other input.
- Values during reset:
  - bcd=12'h000, blank=0, src=0, bcd_err=0.
  - State is TIMER; tick divider, hold counter and flash counter are all 0.
- Tick prescaler:
  - div_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick is a one-cycle strobe when div_cnt==TICK_DIV-1.
  - The prescaler runs freely. State changes do not reset it.
- Priority among inputs sampled in the same cycle: game_over > hit_pulse > tick.
- State TIMER (src=0):
  - game_over=1 -> OVER_ON, flash_cnt=FLASH_MS.
  - else hit_pulse=1 -> SCORE, hold_cnt=HOLD_MS.
- State SCORE (src=1):
  - game_over=1 -> OVER_ON, flash_cnt=FLASH_MS.
  - else hit_pulse=1 -> hold_cnt reloads to HOLD_MS (retrigger).
  - else on tick: hold_cnt decrements. The tick where hold_cnt==1 -> TIMER.
- State OVER_ON (src=2) / OVER_OFF (src=3):
  - game_over=0 -> TIMER, flash_cnt=0.
  - else on tick: flash_cnt decrements. The tick where flash_cnt==1 moves to the other flash state and reloads flash_cnt=FLASH_MS.
  - hit_pulse is ignored in both states.
- Output select, registered, applied in the cycle after the state/input edge (1-cycle latency):
  - TIMER: bcd = clean(time_bcd).
  - SCORE, OVER_ON, OVER_OFF: bcd = clean(score_bcd).
  - blank=1 only in OVER_OFF.
  - Source values are sampled live every cycle, not snapshotted.
- clean(): any nibble greater than 9 is replaced by 0 and sets bcd_err=1. Only the nibbles of the selected source are checked. bcd_err clears only on reset.
- Hold timing: after a hit, SCORE lasts HOLD_MS-1 to HOLD_MS ms depending on where the tick phase falls. This is accepted.
- Counter widths: each counter is wide enough for its parameter; no overflow is possible.
- Reset during SCORE or a flash state returns to TIMER on the next edge with all reset values.

Test Plan:
All scenarios use TICK_DIV=4, HOLD_MS=3, FLASH_MS=2.
1. Apply reset for 2 cycles with time_bcd=12'h045 -> bcd=000, src=0, blank=0 while reset is low. Release reset -> bcd=045 one cycle later.
2. Pulse hit_pulse with score_bcd=12'h123 -> next cycle src=1, bcd=123. After 3 ticks src=0, bcd=time_bcd. A second hit between tick 2 and tick 3 -> SCORE extended by 3 more ticks from that hit.
3. Assert game_over and hit_pulse in the same cycle -> src=2 (not 1). Hold game_over high -> src toggles 2/3 every 2 ticks; blank=1 only while src=3; bcd stays 123.
4. Drop game_over while src=3 -> next cycle src=0, blank=0, bcd=time_bcd.
5. time_bcd=12'h0A7 while in TIMER -> bcd=007 and bcd_err=1. bcd_err stays 1 after the input returns to valid; only reset clears it. Invalid score_bcd while in TIMER -> bcd_err unchanged.
6. Assert reset while src=2 -> next edge src=0, blank=0, bcd=000, bcd_err=0. Release reset with game_over still high -> OVER_ON entered again.

Source files
------------

// File: rtl/disp_source_sched.sv
// Display source scheduler: picks timer, held score or flashing score for the shared
// 3-digit BCD display, scrubs invalid nibbles and drives the blank control.
module disp_source_sched #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned HOLD_MS  = 1000,
    parameter int unsigned FLASH_MS = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] time_bcd,
    input  logic [11:0] score_bcd,
    input  logic        hit_pulse,
    input  logic        game_over,
    output logic [11:0] bcd,
    output logic        blank,
    output logic [1:0]  src,
    output logic        bcd_err
);

    localparam int unsigned DivW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HoldW  = $clog2(HOLD_MS + 1);
    localparam int unsigned FlashW = $clog2(FLASH_MS + 1);

    localparam logic [DivW-1:0]   DivLast   = DivW'(TICK_DIV - 1);
    localparam logic [HoldW-1:0]  HoldLoad  = HoldW'(HOLD_MS);
    localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_MS);

    typedef enum logic [1:0] {
        StTimer   = 2'd0,
        StScore   = 2'd1,
        StOverOn  = 2'd2,
        StOverOff = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [FlashW-1:0] flash_q, flash_d;
    logic [11:0]       bcd_q, bcd_d;
    logic              err_q, err_d;
    logic              tick;
    logic              nib_bad;
    logic [11:0]       sel;

    assign tick = (div_q == DivLast);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        flash_d = flash_q;
        div_d   = tick ? '0 : div_q + 1'b1;

        unique case (state_q)
            StTimer: begin
                if (game_over) begin
                    state_d = StOverOn;
                    flash_d = FlashLoad;
                end else if (hit_pulse) begin
                    state_d = StScore;
                    hold_d  = HoldLoad;
                end
            end
            StScore: begin
                if (game_over) begin
                    state_d = StOverOn;
                    flash_d = FlashLoad;
                    hold_d  = '0;
                end else if (hit_pulse) begin
                    hold_d = HoldLoad;
                end else if (tick) begin
                    if (hold_q == HoldW'(1)) begin
                        state_d = StTimer;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            StOverOn, StOverOff: begin
                if (!game_over) begin
                    state_d = StTimer;
                    flash_d = '0;
                end else if (tick) begin
                    if (flash_q == FlashW'(1)) begin
                        state_d = (state_q == StOverOn) ? StOverOff : StOverOn;
                        flash_d = FlashLoad;
                    end else begin
                        flash_d = flash_q - 1'b1;
                    end
                end
            end
            default: state_d = StTimer;
        endcase

        // Output follows the state being entered, so it lands one edge after the cause.
        sel     = (state_d == StTimer) ? time_bcd : score_bcd;
        bcd_d   = '0;
        nib_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sel[4*i +: 4] > 4'd9) begin
                nib_bad = 1'b1;
            end else begin
                bcd_d[4*i +: 4] = sel[4*i +: 4];
            end
        end
        err_d = err_q | nib_bad;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StTimer;
            div_q   <= '0;
            hold_q  <= '0;
            flash_q <= '0;
            bcd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
            flash_q <= flash_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
        end
    end

    assign bcd     = bcd_q;
    assign src     = state_q;
    assign blank   = (state_q == StOverOff);
    assign bcd_err = err_q;

endmodule

// File: tb/tb_disp_source_sched.sv
// Directed bench for disp_source_sched with TICK_DIV=4, HOLD_MS=3, FLASH_MS=2.
module tb_disp_source_sched;

    logic        clk;
    logic        reset_n;
    logic [11:0] time_bcd;
    logic [11:0] score_bcd;
    logic        hit_pulse;
    logic        game_over;
    logic [11:0] bcd;
    logic        blank;
    logic [1:0]  src;
    logic        bcd_err;

    int n_checks;
    int n_fail;

    disp_source_sched #(
        .TICK_DIV (4),
        .HOLD_MS  (3),
        .FLASH_MS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset_n),
        .time_bcd  (time_bcd),
        .score_bcd (score_bcd),
        .hit_pulse (hit_pulse),
        .game_over (game_over),
        .bcd       (bcd),
        .blank     (blank),
        .src       (src),
        .bcd_err   (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit later.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_src, input logic e_blank,
                             input logic [11:0] e_bcd);
        check_eq({tag, "_src"}, 32'(src), 32'(e_src));
        check_eq({tag, "_blank"}, 32'(blank), 32'(e_blank));
        check_eq({tag, "_bcd"}, 32'(bcd), 32'(e_bcd));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        time_bcd  = 12'h045;
        score_bcd = 12'h000;
        hit_pulse = 1'b0;
        game_over = 1'b0;

        // Reset held for edges 1-2
        step(1);
        check_out("rst1", 2'd0, 1'b0, 12'h000);
        step(1);
        check_out("rst2", 2'd0, 1'b0, 12'h000);
        check_eq("rst_err", 32'(bcd_err), 32'd0);
        reset_n = 1'b1;
        step(1);                                  // edge 3, prescaler now 1
        check_out("rel", 2'd0, 1'b0, 12'h045);

        // Hit at edge 4; ticks sampled at edges 6, 10, 14
        score_bcd = 12'h123;
        hit_pulse = 1'b1;
        step(1);
        hit_pulse = 1'b0;
        check_out("hit", 2'd1, 1'b0, 12'h123);
        step(9);                                  // edge 13
        check_eq("hold_last", 32'(src), 32'd1);
        step(1);                                  // edge 14
        check_out("hold_end", 2'd0, 1'b0, 12'h045);

        // Hit at 15, ticks at 18, 22; retrigger at 23; exit at tick 34
        hit_pulse = 1'b1;
        step(1);
        hit_pulse = 1'b0;
        check_eq("hit2", 32'(src), 32'd1);
        step(7);                                  // edge 22
        hit_pulse = 1'b1;
        step(1);                                  // edge 23
        hit_pulse = 1'b0;
        step(3);                                  // edge 26
        check_eq("retrig_ext", 32'(src), 32'd1);
        step(7);                                  // edge 33
        check_eq("retrig_last", 32'(src), 32'd1);
        step(1);                                  // edge 34
        check_out("retrig_end", 2'd0, 1'b0, 12'h045);

        // game_over beats hit_pulse at edge 35; flash toggles at ticks 42, 50, 58
        game_over = 1'b1;
        hit_pulse = 1'b1;
        step(1);
        hit_pulse = 1'b0;
        check_out("over_pri", 2'd2, 1'b0, 12'h123);
        step(6);                                  // edge 41
        check_out("on_last", 2'd2, 1'b0, 12'h123);
        step(1);                                  // edge 42
        check_out("off1", 2'd3, 1'b1, 12'h123);
        step(7);                                  // edge 49
        check_out("off_last", 2'd3, 1'b1, 12'h123);
        step(1);                                  // edge 50
        check_out("on2", 2'd2, 1'b0, 12'h123);
        step(8);                                  // edge 58
        check_out("off2", 2'd3, 1'b1, 12'h123);

        // Leave game over from OVER_OFF
        game_over = 1'b0;
        step(1);                                  // edge 59
        check_out("over_exit", 2'd0, 1'b0, 12'h045);

        // Invalid time nibble is zeroed and latches bcd_err
        time_bcd = 12'h0A7;
        step(1);
        check_eq("clean_bcd", 32'(bcd), 32'h007);
        check_eq("err_set", 32'(bcd_err), 32'd1);
        time_bcd = 12'h045;
        step(1);
        check_eq("valid_bcd", 32'(bcd), 32'h045);
        check_eq("err_sticky", 32'(bcd_err), 32'd1);

        // Reset while in OVER_ON
        game_over = 1'b1;
        step(1);                                  // edge 62
        check_eq("over_again", 32'(src), 32'd2);
        reset_n = 1'b0;
        step(1);                                  // edge 63
        check_out("rst_over", 2'd0, 1'b0, 12'h000);
        check_eq("rst_err_clr", 32'(bcd_err), 32'd0);
        reset_n = 1'b1;
        step(1);                                  // edge 64, prescaler restarted
        check_out("rel_over", 2'd2, 1'b0, 12'h123);
        step(6);                                  // edge 70
        check_eq("rel_on_last", 32'(src), 32'd2);
        step(1);                                  // edge 71
        check_eq("rel_off", 32'(src), 32'd3);

        // Invalid score while timer is selected leaves bcd_err clear
        game_over = 1'b0;
        score_bcd = 12'h1F3;
        step(1);                                  // edge 72
        check_out("unsel_bad", 2'd0, 1'b0, 12'h045);
        check_eq("unsel_err", 32'(bcd_err), 32'd0);
        step(1);
        check_eq("unsel_err2", 32'(bcd_err), 32'd0);
        hit_pulse = 1'b1;
        step(1);
        hit_pulse = 1'b0;
        check_out("sel_bad", 2'd1, 1'b0, 12'h103);
        check_eq("sel_err", 32'(bcd_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
